nibble_serial_add_ctrl: RTL
===========================

// Module: nibble_serial_add_ctrl
// PURPOSE
//  Sequencer that drives one shared 4-bit ripple-carry adder slice (a,b,ci -> s,co) to add or
//  subtract WIDTH-bit operands, one nibble per clock, LSB nibble first.
//  The carry is registered between nibbles.
//  Used where a wide add/sub is needed but area forbids a WIDTH-bit adder.
//  Valid/ready on both input and result sides.
// PARAMETERS
//  WIDTH  16  operand/result width in bits; multiple of 4, >= 8
//  NIB    (localparam) WIDTH/4, number of nibble passes
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands a, b, op, ci are valid
//  in_ready   out  1      controller can accept a new operation
//  op         in   1      0 = add (a+b+ci); 1 = sub (a-b-ci, ci acts as borrow-in)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  ci         in   1      carry-in (add) / borrow-in (sub)
//  out_valid  out  1      sum, co and ovf are valid
//  out_ready  in   1      consumer accepts the result
//  sum        out  WIDTH  result
//  co         out  1      final carry-out; for sub, 1 = no borrow
//  ovf        out  1      two's-complement signed overflow
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, nibble counter=0, carry reg=0.
//    Operand and result regs clear to 0, so sum=0, co=0, ovf=0, out_valid=0.
//    in_ready=1 (state==IDLE), but no transfer occurs while rst=1.
//  FSM states:
//   IDLE: in_ready=1.
//    On edge with in_valid&&in_ready: latch a, op, and b_eff = op ? ~b : b.
//    Carry reg <= op ? ~ci : ci. cnt <= 0. Go to RUN.
//   RUN: in_ready=0, out_valid=0. Each edge, slice inputs = {A[3:0], Beff[3:0], carry reg}.
//    Slice s is shifted into the top of the result reg; A and Beff shift right by 4.
//    Carry reg <= slice co. cnt++.
//    On the edge where cnt==NIB-1, capture co and ovf and go to DONE.
//    ovf = (a[W-1] ~^ b_eff[W-1]) & (sum[W-1] ^ a[W-1]).
//   DONE: out_valid=1; sum, co and ovf held stable. in_ready=0; in_valid is ignored.
//    On edge with out_ready=1, go to IDLE.
//    Result regs keep their value until the next acceptance.
//  Latency: acceptance edge E0, nibbles processed at E1..E_NIB.
//    out_valid is high from E_NIB until the handshake edge.
//  Throughput: one op per NIB+2 cycles at best. No overlap of ops.
//  The slice is combinational; the controller owns all state. No output depends on out_ready combinationally.
//  in_valid dropping while in RUN or DONE has no effect; operands are already latched.
//  Mid-op reset (RUN or DONE): result discarded, all regs cleared, IDLE on the next cycle after rst deasserts.
//  Carry chain wrap: the carry out of the MSB nibble is not fed back.
//    The carry reg is reloaded from ci on each acceptance.
//  out_ready held high through RUN: DONE still lasts >= 1 cycle; out_valid is never skipped.
//  Sub with b=0, ci=0: sum=a, co=1, ovf=0.
// TESTING (WIDTH=16)
//  1. add a=0x1234, b=0x4321, ci=0 -> sum=0x5555, co=0, ovf=0. out_valid rises exactly 4 edges after acceptance.
//  2. add a=0xFFFF, b=0x0001, ci=0 -> sum=0x0000, co=1, ovf=0 (carry ripples through all 4 nibbles).
//  3. add a=0x7FFF, b=0x0001 -> sum=0x8000, co=0, ovf=1.
//     sub a=0x8000, b=0x0001, ci=0 -> sum=0x7FFF, co=1, ovf=1.
//  4. sub a=0x0003, b=0x0005, ci=1 -> sum=0xFFFD, co=0, ovf=0.
//  5. hold out_ready=0 for 3 cycles in DONE while in_valid=1 with new operands.
//     -> sum, co, ovf stable; in_ready=0; new op accepted only after handshake and return to IDLE.
//  6. assert rst asynchronously 2 cycles into RUN -> out_valid=0, sum=0 immediately.
//     After release, add 0x00FF+0x0001 -> 0x0100, co=0.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// ============================================================================
// nibble_serial_add_ctrl
// ----------------------------------------------------------------------------
// Purpose:
//   Wide add/subtract built around one shared 4-bit ripple-carry slice. The
//   operands are processed one nibble per clock, least-significant nibble
//   first. The carry between nibbles is held in a register. Subtraction is
//   done as a + ~b + ~ci, so ci acts as a borrow-in and co = 1 means no borrow.
//
// Parameters:
//   WIDTH      operand/result width in bits (multiple of 4, >= 8)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   a, b, op and ci are valid
//   in_ready   controller is idle and can accept a new operation
//   op         0 = add (a+b+ci), 1 = sub (a-b-ci)
//   a, b       operands
//   ci         carry-in (add) / borrow-in (sub)
//   out_valid  sum, co and ovf are valid and held
//   out_ready  consumer accepts the result
//   sum        result
//   co         final carry-out (sub: 1 = no borrow)
//   ovf        two's-complement signed overflow
// ============================================================================
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co,
    output logic             ovf
);

    localparam int NIB   = WIDTH / 4;
    localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res;
    logic             co_r;
    logic             ovf_r;
    logic [3:0]       slice_s;
    logic             slice_co;
    logic             accept;
    logic             last;

    // The shared 4-bit slice: pure combinational a + b + carry-in.
    always_comb begin
        {slice_co, slice_s} = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry};
    end

    assign accept = (state == IDLE) && in_valid;
    assign last   = (state == RUN) && (cnt == CNT_W'(NIB - 1));

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (last) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: operand shifters, carry register, result accumulation
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            carry <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            res   <= '0;
            co_r  <= 1'b0;
            ovf_r <= 1'b0;
        end else if (accept) begin
            // Subtraction folds into addition: invert b and the borrow-in.
            a_sh  <= a;
            b_sh  <= op ? ~b : b;
            carry <= op ? ~ci : ci;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sh  <= a_sh >> 4;
            b_sh  <= b_sh >> 4;
            // Each nibble enters at the top; after NIB passes the LSB nibble
            // has walked down to bits [3:0].
            res   <= {slice_s, res[WIDTH-1:4]};
            carry <= slice_co;
            cnt   <= cnt + 1'b1;
            if (last) begin
                co_r  <= slice_co;
                // On the last pass a_sh/b_sh[3] are the original operand sign
                // bits and slice_s[3] is the result sign bit.
                ovf_r <= (a_sh[3] ~^ b_sh[3]) & (slice_s[3] ^ a_sh[3]);
            end
        end
    end

    assign sum = res;
    assign co  = co_r;
    assign ovf = ovf_r;

endmodule
